// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master: all four SPI modes, parametrised word width and
// MSB- or LSB-first shifting behind a start/busy/done handshake.
module spi_master_mc #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE   = 50,
    parameter int unsigned NUM_CS     = 4,
    parameter int unsigned CS_SEL_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CS_SEL_W-1:0]   cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [NUM_CS-1:0]     CS
);
    localparam int unsigned CntW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned EdgeW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [CntW-1:0]  CntLast   = CntW'(PRESCALE - 1);
    localparam logic [EdgeW-1:0] EdgeTotal = EdgeW'(2 * DATA_WIDTH);
    localparam logic [EdgeW-1:0] EdgeFinal = EdgeW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [EdgeW-1:0]      edge_cnt_q, edge_cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, data_out_q, data_out_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
    logic [NUM_CS-1:0]     cs_q, cs_d;
    logic                  tick, sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_q       <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_q       <= cs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_d       = cs_q;
        tick       = (cnt_q == CntLast);
        // Even edge counts are leading edges; sampling happens on the leading
        // edge for cpha=0 and on the trailing edge for cpha=1.
        sample     = (edge_cnt_q[0] == cpha_q);

        unique case (state_q)
            StIdle: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                if (start) begin
                    state_d    = StSetup;
                    cnt_d      = '0;
                    edge_cnt_d = '0;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    lsb_d      = lsb_first;
                    tx_d       = data_in;
                    rx_d       = '0;
                    busy_d     = 1'b1;
                    // Out-of-range selects shift the bit away, leaving all CS high.
                    cs_d       = ~(NUM_CS'(1) << cs_sel);
                    if (!cpha) begin
                        mosi_d = lsb_first ? data_in[0] : data_in[DATA_WIDTH-1];
                        tx_d   = lsb_first ? (data_in >> 1) : (data_in << 1);
                    end
                end
            end
            StSetup, StXfer: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d = '0;
                    if (state_q == StXfer && edge_cnt_q == EdgeTotal) begin
                        state_d = StHold;
                    end else begin
                        state_d    = StXfer;
                        sclk_d     = ~sclk_q;
                        edge_cnt_d = edge_cnt_q + 1'b1;
                        if (sample) begin
                            rx_d = lsb_q ? {MISO, rx_q[DATA_WIDTH-1:1]}
                                         : {rx_q[DATA_WIDTH-2:0], MISO};
                        end else if (edge_cnt_q != EdgeFinal) begin
                            mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
                            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                        end
                    end
                end
            end
            StHold: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    cs_d       = '1;
                    data_out_d = rx_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    mosi_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign CS       = cs_q;
endmodule

// File: doc/spi_master_mc.md
# spi_master_mc

Parametrised multi-chip-select SPI master supporting all four SPI modes, configurable word width, and MSB- or LSB-first shifting. It succeeds the single-mode 8-bit master used in the board-level loopback top. It sits between a local controller (start/busy/done handshake) and up to NUM_CS external SPI slaves sharing SCLK/MOSI/MISO.

## Interface
- DATA_WIDTH, 8: bits per transfer (≥2).
- PRESCALE, 50: clk cycles per SCLK half-period (≥1).
- NUM_CS, 4: number of active-low chip selects.
- CS_SEL_W, 2: width of cs_sel (≥1).

Reset is asynchronous and active-high, on port rst. All logic is clocked by a single clock, clk.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  transfer request, sampled only in IDLE.
- data_in  in  DATA_WIDTH  word to transmit, latched on accepted start.
- cs_sel  in  CS_SEL_W  slave index, latched on accepted start.
- cpol  in  1  clock polarity, latched on accepted start.
- cpha  in  1  clock phase, latched on accepted start.
- lsb_first  in  1  1 = shift LSB first, latched on accepted start.
- data_out  out  DATA_WIDTH  last received word, held until the next done.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at transfer end.
- SCLK  out  1  SPI clock.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in, sampled on clk.
- CS  out  NUM_CS  active-low selects, one-hot-low during transfer.

## Operation
- Reset values: data_out=0, busy=0, done=0, SCLK=0, MOSI=0, CS=all 1; FSM enters IDLE.
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE:
  - SCLK registers the live cpol input every cycle.
  - MOSI=0.
  - start=1 latches data_in, cs_sel, cpol, cpha and lsb_first into the shift register and mode registers, then goes to SETUP.
- SETUP:
  - Lasts PRESCALE cycles.
  - CS[cs_sel] is driven low and busy is high.
  - If cpha=0, MOSI presents the first bit (MSB, or LSB when lsb_first=1).
- XFER:
  - Runs 2*DATA_WIDTH half-periods, with SCLK toggling at the end of each half-period.
  - cpha=0: MISO is sampled on the leading edge; MOSI advances on the trailing edge, except after the final bit.
  - cpha=1: MOSI advances on the leading edge (the first leading edge presents the first bit); MISO is sampled on the trailing edge.
  - Received bits fill the register in the same order as transmitted, so a loopback returns data_in unchanged.
- HOLD:
  - Lasts PRESCALE cycles, with SCLK at the latched cpol and CS still asserted.
  - On exit: CS goes all 1, data_out takes the received word, done pulses, busy drops, MOSI goes to 0.
- start while busy=1 is ignored; it is neither queued nor able to corrupt the latched values.
- cs_sel ≥ NUM_CS: the transfer runs normally with all CS held high; data_out still captures MISO.
- Mode inputs changing mid-transfer have no effect.
- rst mid-transfer: all outputs immediately return to their reset values; no done pulse and no data_out update occur.

## Timing
- start accepted on clk edge T0 → busy=1 and CS low from T0+1.
- The first SCLK edge is at T0+1+PRESCALE.
- The last SCLK edge is at T0+1+PRESCALE+(2*DATA_WIDTH−1)*PRESCALE... (edges spaced PRESCALE apart).
- done=1, busy=0, CS high and data_out valid during cycle T0+1+(2*DATA_WIDTH+2)*PRESCALE.
- busy is high for exactly (2*DATA_WIDTH+2)*PRESCALE cycles.
- A new start is accepted in the cycle busy is low. The earliest accepted start is on the edge following done, giving back-to-back transfers with a one-cycle gap.
- SCLK duty is exactly 50%, with a half-period of PRESCALE clk cycles.

## Test plan
- DATA_WIDTH=8, PRESCALE=4, mode 0, MOSI looped to MISO, data_in=0xA5, cs_sel=1:
  - data_out=0xA5;
  - CS=4'b1101 during the transfer;
  - busy high for 72 cycles;
  - exactly 8 rising SCLK edges.
- Mode 3 (cpol=1, cpha=1) against a slave model returning 0x3C, data_in=0xC3:
  - slave receives 0xC3 and data_out=0x3C;
  - SCLK idles high before and after.
- lsb_first=1, loopback, data_in=0x01:
  - MOSI is 1 during the first bit period only;
  - data_out=0x01.
- start re-pulsed mid-transfer with data_in=0xFF:
  - the in-flight transfer completes with its original word;
  - exactly one done pulse;
  - busy timing unchanged.
- rst asserted at half the transfer:
  - CS=all 1, SCLK=0, busy=0, data_out keeps its prior value of 0;
  - no done pulse.
- cs_sel=3 with NUM_CS=3:
  - CS stays all 1 throughout;
  - done still pulses after (2*DATA_WIDTH+2)*PRESCALE cycles.
